// File: rtl/rca_pkg.sv
// -----------------------------------------------------------------------------
// rca_pkg
//   Shared definitions for the pipelined ripple-carry adder.
//   - rca_mode_e    : operation select carried on the 'sub' input
//   - DEFAULT_WIDTH : default operand width in bits
//   - DEFAULT_SLICE : default number of bits added per pipeline stage
// -----------------------------------------------------------------------------
package rca_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } rca_mode_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

endpackage : rca_pkg

// File: rtl/rca_slice.sv
// -----------------------------------------------------------------------------
// rca_slice
//   Combinational SLICE-bit adder used as one stage of the pipelined adder.
//   Ports:
//     a_i, b_i  [SLICE-1:0] : operand slices (b_i already inverted for subtract)
//     cin_i                 : carry into bit 0 of the slice
//     s_o       [SLICE-1:0] : slice sum
//     cout_o                : carry out of the slice MSB
//     cmsb_o                : carry into the slice MSB (for signed overflow)
// -----------------------------------------------------------------------------
module rca_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE:0] sum_full;

    assign sum_full = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
    assign s_o      = sum_full[SLICE-1:0];
    assign cout_o   = sum_full[SLICE];
    // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls
    // out by cancelling the operand bits; works for any SLICE including 1.
    assign cmsb_o   = sum_full[SLICE-1] ^ a_i[SLICE-1] ^ b_i[SLICE-1];

endmodule : rca_slice

// File: rtl/pipelined_rca.sv
// -----------------------------------------------------------------------------
// pipelined_rca
//   WIDTH-bit adder/subtractor split into NSTAGE = WIDTH/SLICE pipeline
//   stages, each adding one SLICE-bit slice with the previous stage's
//   registered carry. Operands and partial sums travel in skew registers.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid/in_ready   : operand handshake (a, b, cin, sub)
//     out_valid/out_ready : result handshake (s, cout, ovf, zero)
//     cout                : carry-out (add) or NOT borrow-out (subtract)
//     ovf                 : two's-complement overflow
//     zero                : s == 0
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready is the global advance (!out_valid || out_ready); the
//   whole pipe shifts together or holds together, so a held result keeps its
//   output fields stable and a new set may enter in the same cycle the oldest
//   one leaves.
// -----------------------------------------------------------------------------
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTAGE = WIDTH / SLICE;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("pipelined_rca: WIDTH must be a multiple of SLICE");
    end

    logic advance;

    // Stage inputs (what each stage sees this cycle)
    logic             v_in [NSTAGE];
    logic             c_in [NSTAGE];
    logic [WIDTH-1:0] a_in [NSTAGE];
    logic [WIDTH-1:0] b_in [NSTAGE];
    logic [WIDTH-1:0] s_in [NSTAGE];

    // Stage registers and their next values
    logic             v_q [NSTAGE];
    logic             v_d [NSTAGE];
    logic             c_q [NSTAGE];
    logic             c_d [NSTAGE];
    logic [WIDTH-1:0] a_q [NSTAGE];
    logic [WIDTH-1:0] a_d [NSTAGE];
    logic [WIDTH-1:0] b_q [NSTAGE];
    logic [WIDTH-1:0] b_d [NSTAGE];
    logic [WIDTH-1:0] s_q [NSTAGE];
    logic [WIDTH-1:0] s_d [NSTAGE];

    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [SLICE-1:0] sl_s;
        logic             sl_c;
        logic             sl_m;
        logic [WIDTH-1:0] s_next;
        // Low operand bits and the last stage's operand copy are never read
        logic             unused_ops;

        if (k == 0) begin : g_first
            // Subtract is a + ~b + ~cin; the inversion is applied once here
            assign v_in[k] = in_valid;
            assign a_in[k] = a;
            assign b_in[k] = (sub == MODE_SUB) ? ~b : b;
            assign c_in[k] = (sub == MODE_SUB) ? ~cin : cin;
            assign s_in[k] = '0;
        end else begin : g_next
            assign v_in[k] = v_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = s_q[k-1];
        end

        rca_slice #(.SLICE(SLICE)) u_slice (
            .a_i    (a_in[k][k*SLICE +: SLICE]),
            .b_i    (b_in[k][k*SLICE +: SLICE]),
            .cin_i  (c_in[k]),
            .s_o    (sl_s),
            .cout_o (sl_c),
            .cmsb_o (sl_m)
        );

        always_comb begin
            s_next = s_in[k];
            s_next[k*SLICE +: SLICE] = sl_s;
        end

        assign v_d[k] = v_in[k];
        assign a_d[k] = a_in[k];
        assign b_d[k] = b_in[k];
        assign c_d[k] = sl_c;
        assign s_d[k] = s_next;

        assign unused_ops = ^{a_q[k], b_q[k]};

        if (k == NSTAGE - 1) begin : g_last
            assign ovf_d  = sl_m ^ sl_c;
            assign zero_d = (s_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[NSTAGE-1];
    assign s         = s_q[NSTAGE-1];
    assign cout      = c_q[NSTAGE-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule : pipelined_rca

// File: tb/tb_pipelined_rca.sv
// -----------------------------------------------------------------------------
// tb_pipelined_rca
//   Scoreboard bench for pipelined_rca (WIDTH=16, SLICE=4). The driver pushes
//   the reference result of every accepted set; a monitor pops and compares
//   each result the DUT hands over.
// -----------------------------------------------------------------------------
module tb_pipelined_rca;

    localparam int W   = 16;
    localparam int SL  = 4;
    localparam int NST = W / SL;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    pipelined_rca #(.WIDTH(W), .SLICE(SL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // ---------------- scoreboard state ----------------
    int           errors = 0;
    int           checks = 0;
    logic [W+2:0] exp_q[$];   // {s, cout, ovf, zero}
    int           acc_q[$];   // cycle of acceptance
    bit           lat_check  = 1'b0;
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        longint      ua, ub, ur, sa, sb, sr;
        logic [63:0] urv;
        logic [W-1:0] rs;
        logic        rc, ro, rz;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            ur = ua - ub - longint'(mc);
            sr = sa - sb - longint'(mc);
            rc = (ua >= ub + longint'(mc));           // no borrow
        end else begin
            ur = ua + ub + longint'(mc);
            sr = sa + sb + longint'(mc);
            rc = (ur >= (longint'(1) << W));
        end
        urv = ur;
        rs  = urv[W-1:0];
        ro  = (sr > 32767) || (sr < -32768);
        rz  = (rs == '0);
        return {rs, rc, ro, rz};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W+2:0] e;
        int           t;
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got s=0x%0h with empty queue (t=%0t)", s, $time);
            end else begin
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                check("result", 32'({s, cout, ovf, zero}), 32'(e));
                if (lat_check) check("latency", cyc - t, NST);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the set was accepted
    // with in_valid still high (idle/drain lower it).
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts);
        int waited = 0;
        bit done   = 1'b0;
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        cin = tc;
        sub = ts;
        while (!done) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                exp_q.push_back(model(ta, tb_v, tc, ts));
                acc_q.push_back(cyc);
                done = 1'b1;
            end
            @(negedge clk);
            waited++;
            if (!done && waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int waited = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("reset_outputs", 32'({out_valid, s, cout, ovf, zero}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed corner cases
        lat_check = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);   // wrap to zero, carry out
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);   // positive overflow
        send(16'h8000, 16'h0001, 1'b0, 1'b1);   // negative overflow on subtract
        send(16'h0000, 16'h0000, 1'b1, 1'b1);   // borrow through every slice
        send(16'h1234, 16'h1234, 1'b0, 1'b1);   // subtract to zero
        drain();

        // Back-to-back random sets, full throughput
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Backpressure with a full pipe
        lat_check = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NST; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        a = 16'hA5A5;
        b = 16'h0F0F;
        cin = 1'b1;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_hold", 32'({out_valid, s, cout, ovf, zero}), 32'({1'b1, exp_q[0]}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0));
        acc_q.push_back(cyc);
        @(negedge clk);
        drain();

        // Reset mid-flight
        lat_check = 1'b1;
        for (int i = 0; i < 3; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        out_ready = 1'b0;
        idle(1);
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({out_valid, s, cout, ovf, zero}), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        idle(8);
        send(16'h0102, 16'h0304, 1'b1, 1'b0);
        drain();

        // Random traffic with random backpressure and gaps
        lat_check  = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        drain();

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_pipelined_rca

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4: bits added per pipeline stage; NSTAGE = WIDTH/SLICE stages.
REQ-003 Port clk, input, 1: the block's one clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: an operand set is presented.
REQ-006 Port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port cin, input, 1: carry-in (add) or borrow-in (subtract).
REQ-010 Port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 Port out_valid, output, 1: result fields are valid.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port s, output, WIDTH: sum or difference.
REQ-014 Port cout, output, 1: carry-out (add), or NOT borrow-out (subtract).
REQ-015 Port ovf, output, 1: two's-complement signed overflow.
REQ-016 Port zero, output, 1: s equals 0.

Function
REQ-017 Add: {cout,s} SHALL equal a + b + cin.
REQ-018 Subtract: {cout,s} SHALL equal a + ~b + ~cin, so s = a - b - cin mod 2^WIDTH.
REQ-019 Stage k (0..NSTAGE-1) SHALL add slice k of the operands using stage k-1's registered carry. Stage 0 SHALL use the effective carry-in.
REQ-020 Unconsumed upper operand slices and completed lower sum slices SHALL travel in skew registers alongside each stage.
REQ-021 Each stage SHALL hold a valid bit. A bubble SHALL advance as an invalid entry.
REQ-022 Global advance = !out_valid OR out_ready. On advance every stage SHALL shift one place; otherwise all stages SHALL hold.
REQ-023 in_ready SHALL equal advance. A transfer occurs when in_valid AND in_ready; in_valid without in_ready SHALL NOT be captured.
REQ-024 Latency: a set accepted in cycle t SHALL appear with out_valid in cycle t+NSTAGE when no stall occurs. Stalls SHALL add cycles one for one.
REQ-025 Throughput SHALL be one result per cycle while out_ready is held at 1.
REQ-026 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-027 While out_valid=1 and out_ready=0, s, cout, ovf and zero SHALL stay stable.
REQ-028 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-029 zero SHALL be computed from the final s, registered with the result.
REQ-030 With NSTAGE=1 the block SHALL act as a single registered adder with latency 1.
REQ-031 Simultaneous accept and emit in one cycle with a full pipe SHALL be supported without loss.

Reset
REQ-032 rst_n low SHALL asynchronously clear all stage valid bits, out_valid, s, cout, ovf and zero to 0.
REQ-033 in_ready SHALL read 1 during and after reset.
REQ-034 Reset mid-operation SHALL discard all in-flight sets. After release the first output SHALL come only from a newly accepted set.

Structure
REQ-035 Shared package rca_pkg SHALL hold the mode encoding (ADD=0, SUB=1) and the default WIDTH and SLICE constants.
REQ-036 Sub-module rca_slice SHALL be a combinational SLICE-bit adder (a, b, cin -> s, cout, and carry into its MSB), instantiated once per stage.
REQ-037 An elaboration-time check SHALL reject WIDTH not divisible by SLICE.

Verification (WIDTH=16, SLICE=4, latency 4)
REQ-038 Add: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles s=0x0000, cout=1, zero=1, ovf=0.
REQ-039 Signed overflow: a=0x7FFF, b=0x0001, add -> s=0x8000, ovf=1, cout=0. Subtract: a=0x8000, b=0x0001, cin=0 -> s=0x7FFF, ovf=1, cout=1.
REQ-040 Back-to-back: 8 random sets on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles starting 4 cycles later, matching the model, in order.
REQ-041 Backpressure: out_ready=0 for 5 cycles with a full pipe -> in_ready=0, outputs stable. Release -> all sets delivered, none lost or duplicated.
REQ-042 Reset mid-flight: 3 sets accepted, rst_n pulsed low -> out_valid=0 immediately. No stale result appears after release.
REQ-043 Borrow chain: a=0x0000, b=0x0000, cin=1, sub=1 -> s=0xFFFF, cout=0, zero=0.
